// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI target (slave) engine clocked by the system clock.
// SCK, NSS and MOSI are oversampled through SYNC_STAGES flops; SCK edges are found by
// comparing the synchronized level against one extra flop. Received words leave on a
// valid/ready RX port; transmit words are taken from a valid/ready TX port.
//
// Ports:
//   clk_i, rst_n_i          system clock, asynchronous active-low reset
//   cpol_i, cpha_i, lsb_i   SPI mode and bit order, latched at selection
//   len_i                   word length 0..3 -> 8/16/24/32 bits (clamped to DATA_W)
//   tx_data_i/tx_valid_i    next TX word; tx_ready_o pulses when it is consumed
//   rx_data_o/rx_valid_o    received word; rx_ready_i accepts it
//   overrun_o               word completed while the previous one was still unread
//   underrun_o              TX load attempted with no TX word available
//   busy_o                  target selected
//   spi_sck_i, spi_nss_i, spi_mosi_i, spi_miso_o, spi_miso_oe_o   SPI pins
module spi_slave_core #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_i,
    input  logic [1:0]        len_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              overrun_o,
    output logic              underrun_o,
    output logic              busy_o,
    input  logic              spi_sck_i,
    input  logic              spi_nss_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o
);

    localparam int unsigned CntW     = $clog2(DATA_W);
    localparam logic [5:0]  DataWLen = 6'(DATA_W);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // ---------------------------------------------------------------- synchronizers
    logic [SYNC_STAGES-1:0] sck_sync_q, nss_sync_q, mosi_sync_q;
    logic [SYNC_STAGES:0]   sck_chain, nss_chain, mosi_chain;

    assign sck_chain  = {sck_sync_q, spi_sck_i};
    assign nss_chain  = {nss_sync_q, spi_nss_i};
    assign mosi_chain = {mosi_sync_q, spi_mosi_i};

    logic sck_prev_q, nss_prev_q;
    logic sck_s, nss_s, mosi_s;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign nss_s  = nss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // NSS chain resets low so a bus that is idle (high) at reset release never looks
    // like a falling edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_sync_q  <= '0;
            nss_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            nss_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= sck_chain[SYNC_STAGES-1:0];
            nss_sync_q  <= nss_chain[SYNC_STAGES-1:0];
            mosi_sync_q <= mosi_chain[SYNC_STAGES-1:0];
            sck_prev_q  <= sck_s;
            nss_prev_q  <= nss_s;
        end
    end

    // ---------------------------------------------------------------- state
    state_e              state_q, state_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [1:0]          len_q, len_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic                load_pend_q, load_pend_d;
    logic                rx_done_q, rx_done_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;

    // ---------------------------------------------------------------- edge decode
    logic              sck_edge, lead_edge, trail_edge, sample_edge, shift_edge, nss_fall;
    logic [5:0]        word_len;
    logic [CntW-1:0]   last_idx;
    logic [DATA_W-1:0] len_mask;

    assign sck_edge    = sck_s ^ sck_prev_q;
    assign lead_edge   = sck_edge & (sck_prev_q == cpol_q);
    assign trail_edge  = sck_edge & (sck_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign nss_fall    = nss_prev_q & ~nss_s;

    always_comb begin
        word_len = ({4'd0, len_q} + 6'd1) << 3;
        if (word_len > DataWLen) begin
            word_len = DataWLen;
        end
    end

    assign last_idx = CntW'(word_len - 6'd1);
    assign len_mask = ~({DATA_W{1'b1}} << word_len);

    // ---------------------------------------------------------------- next state
    logic              tx_load;
    logic [DATA_W-1:0] rx_shift;

    always_comb begin
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        lsb_d       = lsb_q;
        len_d       = len_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        load_pend_d = load_pend_q;
        rx_done_d   = 1'b0;
        tx_load     = 1'b0;
        rx_shift    = rx_sr_q >> 1;
        rx_shift[last_idx] = mosi_s;

        unique case (state_q)
            StIdle: begin
                if (nss_fall) begin
                    state_d     = StActive;
                    cpol_d      = cpol_i;
                    cpha_d      = cpha_i;
                    lsb_d       = lsb_i;
                    len_d       = len_i;
                    bit_cnt_d   = '0;
                    rx_sr_d     = '0;
                    // cpha=0 must present the first bit before the first SCK edge.
                    tx_load     = ~cpha_i;
                    load_pend_d = cpha_i;
                end
            end
            StActive: begin
                if (nss_s) begin
                    state_d     = StIdle;
                    bit_cnt_d   = '0;
                    rx_sr_d     = '0;
                    load_pend_d = 1'b0;
                end else begin
                    if (shift_edge) begin
                        if (load_pend_q) begin
                            tx_load     = 1'b1;
                            load_pend_d = 1'b0;
                        end else begin
                            tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                        end
                    end
                    if (sample_edge) begin
                        rx_sr_d = lsb_q ? rx_shift : {rx_sr_q[DATA_W-2:0], mosi_s};
                        if (bit_cnt_q == last_idx) begin
                            bit_cnt_d   = '0;
                            rx_done_d   = 1'b1;
                            load_pend_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CntW'(1);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Bits above the word length never reach the MISO tap before the next load,
        // so the TX word is loaded unmasked.
        if (tx_load) begin
            tx_sr_d = tx_valid_i ? tx_data_i : '0;
        end
    end

    // RX delivery runs one cycle after the final sample, independent of NSS.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
        if (rx_done_q && (!rx_valid_q || rx_ready_i)) begin
            rx_data_d  = rx_sr_q & len_mask;
            rx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            len_q       <= 2'd0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            load_pend_q <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            lsb_q       <= lsb_d;
            len_q       <= len_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            load_pend_q <= load_pend_d;
            rx_done_q   <= rx_done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign tx_ready_o    = tx_load & tx_valid_i;
    assign underrun_o    = tx_load & ~tx_valid_i;
    assign overrun_o     = rx_done_q & rx_valid_q & ~rx_ready_i;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign busy_o        = (state_q == StActive);
    assign spi_miso_oe_o = (state_q == StActive);
    assign spi_miso_o    = (state_q == StActive) &&
                           (lsb_q ? tx_sr_q[0] : tx_sr_q[last_idx]);

endmodule

// File: tb/tb_spi_slave_core.sv
// Testbench for spi_slave_core: a behavioural SPI master drives table-driven transfers
// in all four modes plus hand-written overrun, abort and reset sequences.
module tb_spi_slave_core;

    localparam int DW   = 32;
    localparam int SS   = 2;
    localparam int HALF = 8;   // SCK half period in system clocks

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, cpol, cpha, lsb;
    logic [1:0]    len;
    logic [DW-1:0] tx_data;
    logic          tx_valid, rx_ready, sck, nss, mosi;
    logic          tx_ready_o, rx_valid_o, overrun_o, underrun_o, busy_o, miso_o, miso_oe_o;
    logic [DW-1:0] rx_data_o;

    spi_slave_core #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb), .len_i(len),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
        .overrun_o(overrun_o), .underrun_o(underrun_o), .busy_o(busy_o),
        .spi_sck_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi),
        .spi_miso_o(miso_o), .spi_miso_oe_o(miso_oe_o)
    );

    int checks = 0, failures = 0;
    int txr_cnt = 0, und_cnt = 0, ovr_cnt = 0;
    logic [31:0] rxq[$];
    logic [31:0] txq[$];
    int   tx_idx = 0;
    bit   tx_adv = 1'b0;
    logic prev_valid = 1'b0, prev_hs = 1'b0;

    typedef struct {
        logic cpol, cpha, lsb; logic [1:0] len;
        int nw, ntx;
        logic [31:0] mo0, mo1, tx0, tx1, rx0, rx1, mi0, mi1;
        int txr, und;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tx_present();
        if (tx_idx < txq.size()) begin
            tx_valid = 1'b1;
            tx_data  = txq[tx_idx];
        end else begin
            tx_valid = 1'b0;
            tx_data  = '0;
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rxq.size()) return rxq[i];
        return 32'hxxxx_xxxx;
    endfunction

    // Monitor sits on the falling clock edge, away from DUT updates.
    always @(negedge clk) begin
        if (tx_ready_o) begin
            txr_cnt++;
            tx_adv = 1'b1;
        end
        if (underrun_o) und_cnt++;
        if (overrun_o) ovr_cnt++;
        if (rx_valid_o && (!prev_valid || prev_hs)) rxq.push_back(rx_data_o);
        prev_valid = rx_valid_o;
        prev_hs    = rx_valid_o && rx_ready;
    end

    // TX producer: next word appears after the consuming edge.
    always @(posedge clk) begin
        #1;
        if (tx_adv) begin
            tx_adv = 1'b0;
            tx_idx++;
            tx_present();
        end
    end

    task automatic set_cfg(input logic pol, input logic ph, input logic l, input logic [1:0] ln);
        cpol = pol; cpha = ph; lsb = l; len = ln;
        sck  = pol;
        tick(HALF);
    endtask

    task automatic load_tx(input int n, input logic [31:0] w0, input logic [31:0] w1);
        txq = {};
        if (n > 0) txq.push_back(w0);
        if (n > 1) txq.push_back(w1);
        tx_idx = 0;
        tx_present();
    endtask

    task automatic sel();
        nss = 1'b0;
        tick(HALF);
    endtask

    task automatic desel();
        tick(HALF);
        nss = 1'b1;
        tick(4 * HALF);
    endtask

    task automatic xfer(input int nbits, input int nsend, input logic l, input logic ph,
                        input logic pol, input logic [31:0] mo, output logic [31:0] mi);
        mi = '0;
        for (int i = 0; i < nsend; i++) begin
            int b;
            b = l ? i : nbits - 1 - i;
            if (!ph) begin
                mosi = mo[b];
                tick(HALF);
                mi[b] = miso_o;
                sck = ~pol;
                tick(HALF);
                sck = pol;
            end else begin
                sck  = ~pol;
                mosi = mo[b];
                tick(HALF);
                mi[b] = miso_o;
                sck = pol;
                tick(HALF);
            end
        end
    endtask

    initial begin
        logic [31:0] mi;
        vec_t t;
        int nbits;

        //           pol ph lsb len nw ntx mo0           mo1           tx0           tx1
        //           rx0           rx1           mi0           mi1           txr und
        vecs[0] = '{0, 0, 0, 2'd0, 1, 1, 32'hA5, 32'h0, 32'h3C, 32'h0,
                    32'hA5, 32'h0, 32'h3C, 32'h0, 1, 1};
        vecs[1] = '{1, 1, 1, 2'd3, 2, 2, 32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE,
                    32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 2, 0};
        vecs[2] = '{0, 1, 0, 2'd1, 1, 0, 32'hBEEF, 32'h0, 32'h0, 32'h0,
                    32'hBEEF, 32'h0, 32'h0, 32'h0, 0, 1};
        vecs[3] = '{1, 0, 1, 2'd2, 1, 1, 32'hFF00A5C3, 32'h0, 32'hAB123456, 32'h0,
                    32'h00A5C3, 32'h0, 32'h123456, 32'h0, 1, 1};
        vecs[4] = '{0, 0, 1, 2'd1, 2, 2, 32'h1234, 32'hABCD, 32'h5555, 32'h0F0F,
                    32'h1234, 32'hABCD, 32'h5555, 32'h0F0F, 2, 1};
        vecs[5] = '{0, 1, 0, 2'd0, 1, 1, 32'h81, 32'h0, 32'h7E, 32'h0,
                    32'h81, 32'h0, 32'h7E, 32'h0, 1, 0};

        rst_n = 1'b0; cpol = 0; cpha = 0; lsb = 0; len = 0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
        sck = 1'b0; nss = 1'b1; mosi = 1'b0;
        tick(4);
        check("reset rx_data", rx_data_o, 32'h0);
        check("reset rx_valid", {31'b0, rx_valid_o}, 32'h0);
        check("reset busy/oe", {30'b0, busy_o, miso_oe_o}, 32'h0);
        check("reset miso", {31'b0, miso_o}, 32'h0);
        check("reset pulses", {29'b0, tx_ready_o, underrun_o, overrun_o}, 32'h0);
        rst_n = 1'b1;
        tick(HALF);

        // ---------------------------------------------------- table-driven transfers
        for (int v = 0; v < 6; v++) begin
            t = vecs[v];
            nbits = (int'(t.len) + 1) * 8;
            set_cfg(t.cpol, t.cpha, t.lsb, t.len);
            load_tx(t.ntx, t.tx0, t.tx1);
            rxq = {};
            txr_cnt = 0; und_cnt = 0; ovr_cnt = 0;
            sel();
            check($sformatf("v%0d busy", v), {31'b0, busy_o}, 32'h1);
            check($sformatf("v%0d tx_ready at select", v), txr_cnt,
                  (!t.cpha && t.ntx > 0) ? 1 : 0);
            xfer(nbits, nbits, t.lsb, t.cpha, t.cpol, t.mo0, mi);
            check($sformatf("v%0d miso w0", v), mi, t.mi0);
            if (t.nw > 1) begin
                xfer(nbits, nbits, t.lsb, t.cpha, t.cpol, t.mo1, mi);
                check($sformatf("v%0d miso w1", v), mi, t.mi1);
            end
            desel();
            check($sformatf("v%0d rx count", v), rxq.size(), t.nw);
            check($sformatf("v%0d rx w0", v), rx_at(0), t.rx0);
            if (t.nw > 1) check($sformatf("v%0d rx w1", v), rx_at(1), t.rx1);
            check($sformatf("v%0d tx_ready count", v), txr_cnt, t.txr);
            check($sformatf("v%0d underrun count", v), und_cnt, t.und);
            check($sformatf("v%0d overrun count", v), ovr_cnt, 0);
            check($sformatf("v%0d idle oe", v), {31'b0, miso_oe_o}, 32'h0);
        end

        // ---------------------------------------------------- overrun
        set_cfg(0, 0, 0, 2'd0);
        load_tx(0, 0, 0);
        rxq = {}; ovr_cnt = 0;
        rx_ready = 1'b0;
        sel();
        xfer(8, 8, 0, 0, 0, 32'h11, mi);
        xfer(8, 8, 0, 0, 0, 32'h22, mi);
        desel();
        check("ovr rx_data kept", rx_data_o, 32'h11);
        check("ovr rx_valid", {31'b0, rx_valid_o}, 32'h1);
        check("ovr pulse count", ovr_cnt, 1);
        check("ovr rx deliveries", rxq.size(), 1);
        rx_ready = 1'b1;
        tick(2);
        check("ovr rx_valid cleared", {31'b0, rx_valid_o}, 32'h0);

        // ---------------------------------------------------- abort after 5 of 8 bits
        load_tx(1, 32'h99, 0);
        rxq = {};
        sel();
        xfer(8, 5, 0, 0, 0, 32'hFF, mi);
        tick(HALF);
        check("abort oe before", {31'b0, miso_oe_o}, 32'h1);
        nss = 1'b1;
        tick(SS + 1);
        check("abort oe dropped", {31'b0, miso_oe_o}, 32'h0);
        check("abort busy dropped", {31'b0, busy_o}, 32'h0);
        tick(2 * HALF);
        check("abort no rx", rxq.size(), 0);
        load_tx(1, 32'hC3, 0);
        sel();
        xfer(8, 8, 0, 0, 0, 32'h5A, mi);
        desel();
        check("after abort rx", rx_at(0), 32'h5A);
        check("after abort miso", mi, 32'hC3);

        // ---------------------------------------------------- async reset mid-word, mode 2
        set_cfg(1, 0, 0, 2'd0);
        load_tx(1, 32'h96, 0);
        rxq = {};
        sel();
        xfer(8, 4, 0, 0, 1, 32'hFF, mi);
        rst_n = 1'b0;
        #1;
        check("rst rx_data", rx_data_o, 32'h0);
        check("rst outputs", {25'b0, busy_o, miso_oe_o, miso_o, rx_valid_o, tx_ready_o,
                              underrun_o, overrun_o}, 32'h0);
        nss = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(HALF);
        load_tx(1, 32'h96, 0);
        rxq = {};
        sel();
        xfer(8, 8, 0, 0, 1, 32'hFF, mi);
        desel();
        check("post-reset rx", rx_at(0), 32'hFF);
        check("post-reset miso", mi, 32'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
SPI target-side (slave) engine, the counterpart of the team's APB4 SPI master. It is clocked by the system clock and oversamples an external master's SCK, NSS and MOSI. Received words are delivered on a valid/ready RX port and transmit words are taken from a valid/ready TX port. It is intended to sit under a future APB4 slave-register wrapper or to be used standalone in SoC bring-up.

Parameters:
DATA_W, 32, maximum word width; must be a multiple of 8, range 8..32.
SYNC_STAGES, 2, synchronizer depth for spi_sck_i, spi_nss_i and spi_mosi_i.

Ports:
clk_i  in  1  system clock; must run at ≥6× SCK frequency.
rst_n_i  in  1  reset, asynchronous, active-low.
cpol_i  in  1  SCK idle level.
cpha_i  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
lsb_i  in  1  1 = LSB first.
len_i  in  2  word length: 0→8, 1→16, 2→24, 3→32 bits (clamped to DATA_W).
tx_data_i  in  DATA_W  next word to transmit, right-aligned.
tx_valid_i  in  1  TX word available.
tx_ready_o  out  1  one-cycle pulse when tx_data_i is consumed.
rx_data_o  out  DATA_W  received word, right-aligned, zero-extended.
rx_valid_o  out  1  rx_data_o holds an unread word.
rx_ready_i  in  1  consumer accepts rx_data_o.
overrun_o  out  1  one-cycle pulse: a word completed while rx_valid_o=1.
underrun_o  out  1  one-cycle pulse: word load attempted while tx_valid_i=0.
busy_o  out  1  selected (synced NSS low).
spi_sck_i  in  1  SPI clock from master.
spi_nss_i  in  1  chip select, active-low.
spi_mosi_i  in  1  data from master.
spi_miso_o  out  1  data to master.
spi_miso_oe_o  out  1  MISO output enable.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; shift registers and bit counter cleared.
- Synchronization: SYNC_STAGES flops on every SPI input, plus one extra SCK flop for edge detection. Leading edge = synced SCK leaving cpol; trailing edge = synced SCK returning to cpol. sample_edge = leading if cpha=0, else trailing; shift_edge = the other edge.
- FSM IDLE→ACTIVE on synced NSS falling edge. cpol/cpha/lsb/len are latched at that point and ignored until the next selection. ACTIVE→IDLE on synced NSS high, from any point.
- In ACTIVE: spi_miso_oe_o=1 and busy_o=1. In IDLE: both 0 and spi_miso_o=0.
- TX word load:
  - cpha=0: at NSS fall, and at the first shift_edge after a word's final sample.
  - cpha=1: at the first shift_edge of each word.
  - Load with tx_valid_i=1: shift register ← tx_data_i and tx_ready_o pulses in that same cycle.
  - Load with tx_valid_i=0: shift register ← 0 and underrun_o pulses.
- MISO: spi_miso_o = current bit; bit[len-1] when lsb=0, bit[0] when lsb=1. It advances only on shift_edge, never on sample_edge.
- RX: on sample_edge the synced MOSI is shifted in and bit_cnt increments. When bit_cnt reaches len-1 the word is complete and bit_cnt wraps to 0.
- Word completion, one cycle after the final sample_edge:
  - If rx_valid_o=0 or rx_ready_i=1: rx_data_o ← word and rx_valid_o=1.
  - Else: the old data is kept, the new word is dropped and overrun_o pulses.
- rx_valid_o clears when rx_valid_o & rx_ready_i and no new word completes in that cycle.
- Width rules: unused upper bits of tx_data_i are ignored; upper bits of rx_data_o are 0. In LSB-first mode the first received bit lands at bit 0.
- Back-to-back words continue with no gap while NSS stays low.
- NSS high mid-word: partial RX word discarded, no rx_valid_o, bit_cnt←0. An already-consumed TX word is lost and is not re-requested.
- Reset mid-transfer: immediate return to the reset state. The master must deassert NSS before the next transfer.
- SCK edges while in IDLE are ignored.

Test Plan:
- Mode 0, len=8, MSB first: master sends 0xA5 while tx_data_i=0x3C valid → MISO bits 0,0,1,1,1,1,0,0; rx_data_o=0x000000A5 with rx_valid_o; tx_ready_o pulses once, at NSS fall.
- Mode 3, len=32, LSB first, two back-to-back words 0x12345678 and 0xDEADBEEF with TX words 0xCAFEF00D and 0x0BADC0DE → both RX words correct in order; two tx_ready_o pulses, each on the first shift edge of its word.
- Overrun: rx_ready_i=0, master sends 0x11 then 0x22 (len=8) → rx_data_o stays 0x11; overrun_o pulses once, 1 cycle after the 16th sample edge.
- Underrun: tx_valid_i=0 at NSS fall, mode 1, len=16 → MISO all zeros; underrun_o pulses once; RX word still delivered.
- Abort: NSS rises after 5 of 8 bits → no rx_valid_o; spi_miso_oe_o drops within SYNC_STAGES+1 cycles. The next full transfer of 0x5A is received correctly.
- Async reset asserted mid-word in mode 2 → all outputs 0 immediately; after release with NSS high, a transfer of 0xFF receives correctly.
